// File: rtl/log2_pkg.sv
// Shared definitions for the fixed-point log2 back end.
// Contents: operand/result width constants, the FSM state type and the
// packed result type used by log2_frac_iter and its squaring step.
package log2_pkg;

  localparam int unsigned IN_W   = 128;              // operand width
  localparam int unsigned CLZ_W  = $clog2(IN_W) + 1; // leading-zero count width
  localparam int unsigned INT_W  = $clog2(IN_W);     // integer result bits
  localparam int unsigned FRAC_W = 16;               // fractional bits / iterations
  localparam int unsigned MANT_W = 32;               // mantissa, format 1.(MANT_W-1)
  localparam int unsigned CNT_W  = $clog2(FRAC_W);   // iteration counter width

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } log2_state_t;

  typedef logic [INT_W+FRAC_W-1:0] log2_result_t;

endpackage

// File: rtl/log2_frac_iter_if.sv
// Handshake bundle for log2_frac_iter.
// Input side : i_valid / o_ready carry i_WORD (operand) and i_CLZ (its
//              leading-zero count).
// Output side: o_valid / i_ready carry o_LOG (INT_W.FRAC_W) and o_ZERO.
// Modports: slave = the log2 block, master = the surrounding logic.
interface log2_frac_iter_if;
  import log2_pkg::*;

  logic               i_valid;
  logic               o_ready;
  logic [IN_W-1:0]    i_WORD;
  logic [CLZ_W-1:0]   i_CLZ;
  logic               o_valid;
  logic               i_ready;
  log2_result_t       o_LOG;
  logic               o_ZERO;

  modport slave (
    input  i_valid, i_WORD, i_CLZ, i_ready,
    output o_ready, o_valid, o_LOG, o_ZERO
  );

  modport master (
    output i_valid, i_WORD, i_CLZ, i_ready,
    input  o_ready, o_valid, o_LOG, o_ZERO
  );

endinterface

// File: rtl/log2_sq_step.sv
// One fractional-bit step of the iterative log2: squares the 1.x mantissa
// and renormalizes it back into [1,2).
// Ports: m      - current mantissa, format 1.(MANT_W-1)
//        bit_o  - resulting fractional bit (1 when m*m >= 2)
//        m_next - renormalized square, format 1.(MANT_W-1), truncated
module log2_sq_step
  import log2_pkg::*;
(
  input  logic [MANT_W-1:0] m,
  output logic              bit_o,
  output logic [MANT_W-1:0] m_next
);

  logic [2*MANT_W-1:0] m_ext;
  logic [2*MANT_W-1:0] sq;

  always_comb begin
    m_ext  = {{MANT_W{1'b0}}, m};
    sq     = m_ext * m_ext;           // format 2.(2*MANT_W-2), value in [1,4)
    bit_o  = sq[2*MANT_W-1];
    // Square >= 2: divide by two (take from the top bit); else keep as is.
    m_next = MANT_W'(sq >> (bit_o ? MANT_W : MANT_W - 1));
  end

endmodule

// File: rtl/log2_frac_iter.sv
// Sequential log2 back end behind the CLZ chain.
// Accepts an operand and its leading-zero count, normalizes it to a 1.x
// mantissa and produces log2(i_WORD) as unsigned INT_W.FRAC_W: the integer
// part from the leading-zero count, the fraction by repeated squaring, one
// bit per cycle, MSB first, truncated.
// Ports: clk   - rising-edge clock
//        reset - asynchronous active-low reset
//        bus   - operand/result handshake bundle (slave side)
module log2_frac_iter
  import log2_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  log2_frac_iter_if.slave bus
);

  log2_state_t       state, state_nx;
  logic [INT_W-1:0]  int_r;
  logic [FRAC_W-1:0] frac_r;
  logic [MANT_W-1:0] m_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              zero_r;

  logic              step_bit;
  logic [MANT_W-1:0] step_m;
  logic              accept;
  logic              word_zero;

  log2_sq_step u_sq_step (
    .m      (m_r),
    .bit_o  (step_bit),
    .m_next (step_m)
  );

  assign accept    = (state == IDLE) && bus.i_valid;
  assign word_zero = (bus.i_WORD == '0);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.i_valid) state_nx = word_zero ? DONE : ITER;
      ITER: if (cnt_r == CNT_W'(FRAC_W - 1)) state_nx = DONE;
      DONE: if (bus.i_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_r  <= '0;
      frac_r <= '0;
      m_r    <= '0;
      cnt_r  <= '0;
      zero_r <= 1'b0;
    end else if (accept) begin
      // Integer part wraps modulo 2^INT_W, same as truncating IN_W-1-i_CLZ.
      int_r  <= word_zero ? '0 : INT_W'(IN_W - 1) - bus.i_CLZ[INT_W-1:0];
      m_r    <= MANT_W'((bus.i_WORD << bus.i_CLZ) >> (IN_W - MANT_W));
      frac_r <= '0;
      cnt_r  <= '0;
      zero_r <= word_zero;
    end else if (state == ITER) begin
      m_r    <= step_m;
      frac_r <= {frac_r[FRAC_W-2:0], step_bit};
      cnt_r  <= cnt_r + 1'b1;
    end
  end

  // Outputs; result is only driven while presented so it reads 0 otherwise.
  always_comb begin
    bus.o_ready = (state == IDLE);
    bus.o_valid = (state == DONE);
    bus.o_LOG   = '0;
    bus.o_ZERO  = 1'b0;
    if (state == DONE) begin
      bus.o_LOG  = {int_r, frac_r};
      bus.o_ZERO = zero_r;
    end
  end

endmodule

// File: tb/tb_log2_frac_iter.sv
module tb_log2_frac_iter;
  import log2_pkg::*;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  int   cyc_count;
  int   acc_cyc;

  log2_frac_iter_if bus ();

  log2_frac_iter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_count = 0;
  always @(posedge clk) cyc_count <= cyc_count + 1;

  // Present an operand and return just after the accept edge.
  task automatic do_accept(input logic [IN_W-1:0] w, input logic [CLZ_W-1:0] c);
    int n;
    n = 0;
    @(negedge clk);
    bus.i_WORD  = w;
    bus.i_CLZ   = c;
    bus.i_valid = 1'b1;
    while (bus.o_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    acc_cyc     = cyc_count;
    bus.i_valid = 1'b0;
  endtask

  // Count clock edges after the accept edge until o_valid (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.o_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_LOG !== '0 || bus.o_ZERO !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state ready=%b valid=%b log=%h zero=%b required 1 0 0 0",
               bus.o_ready, bus.o_valid, bus.o_LOG, bus.o_ZERO);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_LOG !== '0) begin
      tests_failed++;
      $display("FAIL reset_release ready=%b valid=%b log=%h required 1 0 0",
               bus.o_ready, bus.o_valid, bus.o_LOG);
    end
  endtask

  task automatic test_one();
    int lat;
    do_accept(128'd1, 8'd127);
    wait_valid(lat);
    tests_run++;
    if (lat !== FRAC_W) begin
      tests_failed++;
      $display("FAIL one_latency got %0d required %0d", lat, FRAC_W);
    end
    tests_run++;
    if (bus.o_LOG !== 23'h000000 || bus.o_ZERO !== 1'b0) begin
      tests_failed++;
      $display("FAIL one_result log=%h zero=%b required 000000 0", bus.o_LOG, bus.o_ZERO);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL one_drain valid=%b ready=%b required 0 1", bus.o_valid, bus.o_ready);
    end
  endtask

  task automatic test_pow100();
    int lat;
    do_accept(128'd1 << 100, 8'd27);
    wait_valid(lat);
    tests_run++;
    if (lat !== FRAC_W || bus.o_LOG !== 23'h640000 || bus.o_ZERO !== 1'b0) begin
      tests_failed++;
      $display("FAIL pow100 lat=%0d log=%h zero=%b required %0d 640000 0",
               lat, bus.o_LOG, bus.o_ZERO, FRAC_W);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_three();
    int lat;
    do_accept(128'd3, 8'd126);
    wait_valid(lat);
    tests_run++;
    if (lat !== FRAC_W || bus.o_LOG !== 23'h0195C0 || bus.o_ZERO !== 1'b0) begin
      tests_failed++;
      $display("FAIL three lat=%0d log=%h zero=%b required %0d 0195c0 0",
               lat, bus.o_LOG, bus.o_ZERO, FRAC_W);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero();
    int lat;
    do_accept(128'd0, 8'd127);
    wait_valid(lat);
    tests_run++;
    if (lat !== 0) begin
      tests_failed++;
      $display("FAIL zero_latency got %0d required 0", lat);
    end
    tests_run++;
    if (bus.o_LOG !== '0 || bus.o_ZERO !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_result log=%h zero=%b required 000000 1", bus.o_LOG, bus.o_ZERO);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_ZERO !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_drain valid=%b ready=%b zero=%b required 0 1 0",
               bus.o_valid, bus.o_ready, bus.o_ZERO);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bus.i_ready = 1'b0;
    do_accept(128'd3, 8'd126);
    wait_valid(lat);
    tests_run++;
    if (lat !== FRAC_W || bus.o_LOG !== 23'h0195C0) begin
      tests_failed++;
      $display("FAIL bp_result lat=%0d log=%h required %0d 0195c0", lat, bus.o_LOG, FRAC_W);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.i_WORD  = 128'd1 << 100;
        bus.i_CLZ   = 8'd27;
        bus.i_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.o_valid !== 1'b1 || bus.o_LOG !== 23'h0195C0 || bus.o_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold cycle %0d valid=%b log=%h ready=%b required 1 0195c0 0",
                 i, bus.o_valid, bus.o_LOG, bus.o_ready);
      end
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release valid=%b ready=%b required 0 1", bus.o_valid, bus.o_ready);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_ignored_input valid=%b ready=%b required 0 1", bus.o_valid, bus.o_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen_valid;
    do_accept(128'd3, 8'd126);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (bus.o_valid !== 1'b0 || bus.o_LOG !== '0 || bus.o_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_abort valid=%b log=%h ready=%b required 0 0 1",
               bus.o_valid, bus.o_LOG, bus.o_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    seen_valid = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.o_valid === 1'b1 || bus.o_ready !== 1'b1) seen_valid = 1'b1;
    end
    tests_run++;
    if (seen_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_no_result stray activity=%b required 0", seen_valid);
    end
    do_accept(128'd1 << 100, 8'd27);
    wait_valid(lat);
    tests_run++;
    if (lat !== FRAC_W || bus.o_LOG !== 23'h640000 || bus.o_ZERO !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_next lat=%0d log=%h zero=%b required %0d 640000 0",
               lat, bus.o_LOG, bus.o_ZERO, FRAC_W);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    int first;
    bus.i_ready = 1'b1;
    do_accept(128'd1 << 100, 8'd27);
    first = acc_cyc;
    do_accept(128'd3, 8'd126);
    tests_run++;
    if (acc_cyc - first !== FRAC_W + 2) begin
      tests_failed++;
      $display("FAIL b2b_throughput got %0d cycles required %0d", acc_cyc - first, FRAC_W + 2);
    end
    wait_valid(lat);
    tests_run++;
    if (lat !== FRAC_W || bus.o_LOG !== 23'h0195C0) begin
      tests_failed++;
      $display("FAIL b2b_second lat=%0d log=%h required %0d 0195c0", lat, bus.o_LOG, FRAC_W);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    acc_cyc      = 0;
    bus.i_valid  = 1'b0;
    bus.i_WORD   = '0;
    bus.i_CLZ    = '0;
    bus.i_ready  = 1'b1;
    test_reset();
    test_one();
    test_pow100();
    test_three();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
